// File: rtl/reg_access_arbiter.sv
// Three-client arbiter and single command path into RegIO.
// Define REG_ARB_ROUND_ROBIN_EN to alternate tx/rx on ties (init stays first).
module reg_access_arbiter #(
  parameter logic [3:0] IDLE_STATE     = 4'd0,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] req_offset,
  input  logic [2:0]  req_length,
  input  logic [2:0]  req_wr,
  input  logic [47:0] req_wdata,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        timeout_err,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        NewCommand,
  output logic [7:0]  offset,
  output logic        length,
  output logic        WR,
  output logic [15:0] writeData,
  input  logic [15:0] readData,
  input  logic [3:0]  reg_state
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n, cnt_inc;
  logic        tmo, tmo_n;
  logic [2:0]  grant_n, win;
  logic [7:0]  offset_n, sel_off;
  logic        length_n, wr_n, sel_len, sel_wr;
  logic [15:0] wdata_n, rd_data_n, sel_wd;
  logic        rio_idle, cnt_hit;

  assign rio_idle = reg_state == IDLE_STATE;
  // Saturating counter: it parks at the limit instead of wrapping.
  assign cnt_inc  = (cnt == TMO) ? cnt : cnt + 10'd1;
  assign cnt_hit  = cnt_inc == TMO;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic last_rx;

  always_comb begin
    if (req[0])
      win = 3'b001;
    else if (req[1] && req[2])
      win = last_rx ? 3'b010 : 3'b100;
    else if (req[2])
      win = 3'b100;
    else if (req[1])
      win = 3'b010;
    else
      win = 3'b000;
  end

  always_ff @(posedge sysclk) begin
    if (reset)
      last_rx <= 1'b1;
    else if (state == S_RESP && (grant[1] || grant[2]))
      last_rx <= grant[2];
  end
`else
  always_comb begin
    if (req[0])
      win = 3'b001;
    else if (req[2])
      win = 3'b100;
    else if (req[1])
      win = 3'b010;
    else
      win = 3'b000;
  end
`endif

  always_comb begin
    sel_off = '0;
    sel_len = 1'b0;
    sel_wr  = 1'b0;
    sel_wd  = '0;
    for (int k = 0; k < 3; k++) begin
      if (win[k]) begin
        sel_off = req_offset[8*k +: 8];
        sel_len = req_length[k];
        sel_wr  = req_wr[k];
        sel_wd  = req_wdata[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tmo_n       = tmo;
    grant_n     = grant;
    offset_n    = offset;
    length_n    = length;
    wr_n        = WR;
    wdata_n     = writeData;
    rd_data_n   = rd_data;
    NewCommand  = 1'b0;
    done        = '0;
    timeout_err = 1'b0;
    busy        = state != S_IDLE;
    unique case (state)
      S_IDLE: begin
        if (|req && rio_idle) begin
          grant_n  = win;
          offset_n = sel_off;
          length_n = sel_len;
          wr_n     = sel_wr;
          wdata_n  = sel_wd;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        NewCommand = 1'b1;
        cnt_n      = '0;
        tmo_n      = 1'b0;
        state_n    = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!rio_idle) begin
          cnt_n   = '0;
          state_n = S_WAIT_DONE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_hit) begin
            tmo_n   = 1'b1;
            state_n = S_RESP;
          end
        end
      end
      S_WAIT_DONE: begin
        if (rio_idle) begin
          rd_data_n = readData;
          state_n   = S_RESP;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_hit) begin
            tmo_n   = 1'b1;
            state_n = S_RESP;
          end
        end
      end
      S_RESP: begin
        done        = grant;
        timeout_err = tmo;
        grant_n     = '0;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tmo       <= 1'b0;
      grant     <= '0;
      offset    <= '0;
      length    <= 1'b0;
      WR        <= 1'b0;
      writeData <= '0;
      rd_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tmo       <= tmo_n;
      grant     <= grant_n;
      offset    <= offset_n;
      length    <= length_n;
      WR        <= wr_n;
      writeData <= wdata_n;
      rd_data   <= rd_data_n;
    end
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Single point of access to RegIO for the Ethernet controller. It replaces the per-signal MUX8/MUX1/MUX16 steering.
- Accepts register-access requests from three clients: Initialization (client 0), Transmission (client 1) and Reception (client 2). It grants one client at a time and issues exactly one NewCommand per transaction.
- It tracks RegIO's state to completion, then returns readData and a done pulse to the granted client.
- Sits directly upstream of RegIO and downstream of the Initialization/Transmission/Reception modules.

Parameters:
- IDLE_STATE, 4'd0, RegIO state code meaning idle / ready for a new command.
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting in WAIT_START or WAIT_DONE before aborting (10-bit counter).

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  3  per-client request; bit0 init, bit1 tx, bit2 rx.
- req_offset  in  24  packed register offsets, client k at [8k+7:8k].
- req_length  in  3  per-client length (0 byte, 1 word).
- req_wr  in  3  per-client direction (1 write, 0 read).
- req_wdata  in  48  packed write data, client k at [16k+15:16k].
- grant  out  3  one-hot; held for the whole transaction.
- done  out  3  one-hot, one-cycle completion pulse.
- timeout_err  out  1  one-cycle pulse coincident with done when the transaction was aborted.
- rd_data  out  16  readData captured at completion; held until the next completion.
- busy  out  1  high in any state other than IDLE.
- NewCommand  out  1  one-cycle command strobe to RegIO.
- offset  out  8  to RegIO.
- length  out  1  to RegIO.
- WR  out  1  to RegIO.
- writeData  out  16  to RegIO.
- readData  in  16  from RegIO.
- reg_state  in  4  RegIO state.

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset applies on the next sysclk edge. A reset during a transaction abandons it with no done pulse and no NewCommand.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - If any req bit is high and reg_state == IDLE_STATE, select a winner. Fixed priority is init > rx > tx.
  - Latch the winner's offset, length, wr and wdata into the output registers and set grant.
  - Go to ISSUE.
  - If reg_state != IDLE_STATE, stay in IDLE without granting.
- ISSUE: NewCommand = 1 for this cycle only. Clear the timeout counter. Go to WAIT_START.
- WAIT_START:
  - When reg_state != IDLE_STATE, go to WAIT_DONE and clear the counter.
  - Otherwise increment the counter. When it equals TIMEOUT_CYCLES, go to RESP with the timeout flag set.
- WAIT_DONE:
  - When reg_state == IDLE_STATE, capture readData into rd_data and go to RESP.
  - On counter == TIMEOUT_CYCLES, go to RESP with the timeout flag set; rd_data is left unchanged.
- RESP:
  - done[granted] = 1 and timeout_err = timeout flag, both for one cycle.
  - grant clears at the end of this cycle. Go to IDLE.
- Latency: req sampled high in IDLE at edge N gives NewCommand high in cycle N+1. Minimum request-to-done time is 4 cycles plus RegIO's busy time.
- Client rules:
  - Hold req and its fields stable from assertion until done.
  - Deassert req in the cycle after done (registered clients satisfy this automatically).
  - A req still high in the IDLE cycle after RESP is treated as a new request.
- Field stability: offset/length/WR/writeData are stable from ISSUE through RESP. They keep their last values while in IDLE.
- Simultaneous requests: exactly one grant. Losers stay pending with no side effects.
- A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- Timeout counter saturates at TIMEOUT_CYCLES and never wraps.

Optional Feature:
- Macro: REG_ARB_ROUND_ROBIN_EN.
- Defined:
  - init keeps absolute priority.
  - tx and rx alternate through a 1-bit last-served pointer, updated in RESP when a tx or rx transaction completes.
  - On a tx/rx tie, the client not served last wins. The pointer resets to "rx served last", so tx wins the first tie.
- Undefined: fixed init > rx > tx priority and no pointer register.

Test Plan:
- Single init write: req=3'b001, offset 8'h22, wdata 16'hA5A5, wr=1. RegIO model is busy 5 cycles. Expect NewCommand exactly once, offset=8'h22, writeData=16'hA5A5, WR=1, then done=3'b001, timeout_err=0.
- Read return: tx reads offset 8'h10 and the model returns readData 16'h1234 on going idle. Expect rd_data=16'h1234 in the same cycle done=3'b010, held afterwards.
- Contention, macro undefined: req=3'b111 in one cycle. Expect grants in the order 001, 100, 010, each with one NewCommand and one done. With the macro defined and only tx/rx requesting twice, expect order 010, 100, 010, 100.
- Timeout: model never leaves IDLE_STATE after NewCommand, with TIMEOUT_CYCLES=8. Expect done plus timeout_err exactly 9 cycles after NewCommand and rd_data unchanged.
- RegIO busy at request: reg_state=4'd3 when req rises. Expect no grant until reg_state returns to 0, then normal issue.
- Reset mid-transaction: assert reset in WAIT_DONE. Expect all outputs 0 on the next edge, no done, and a fresh transaction works after release.
